// File: rtl/alu_seq_ctrl.sv
// Purpose: sequences 32- or 64-bit ALU requests through an external 32-bit ALU in one or two passes.
// Latency: response valid 2 cycles after accept (narrow), 3 cycles after accept (wide).
// Backpressure: holds the response until rsp_ready; req_ready only in IDLE, one cycle after the handshake.
// Optional build macro ALU_SEQ_STATS_EN adds the saturating op_count output.
module alu_seq_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    input  logic             req_cin,
    input  logic             req_wide,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic             alu_cin,
    output logic [3:0]       alu_sel,
    input  logic [31:0]      alu_f,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_f,
    output logic             rsp_cout
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [CNT_W-1:0] op_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  op_q;
    logic [63:0] a_q;
    logic [63:0] b_q;
    logic        cin_q;
    logic        wide_q;
    logic [31:0] lo_f_q;
    logic        lo_cout_q;

    logic        req_acc;
    logic [63:0] wide_f;
    logic        wide_cout;

    // A counter narrower than one bit is meaningless; the block is intentionally empty.
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end

    assign req_acc = req_valid && req_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake outputs and the ALU operand drive for each pass.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = 32'd0;
        alu_b     = 32'd0;
        alu_cin   = 1'b0;
        alu_sel   = 4'd0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = LO;
                end
            end
            LO: begin
                alu_a     = a_q[31:0];
                alu_b     = b_q[31:0];
                alu_cin   = cin_q;
                alu_sel   = op_q;
                state_nxt = wide_q ? HI : RESP;
            end
            HI: begin
                alu_a     = a_q[63:32];
                alu_b     = b_q[63:32];
                // Only arithmetic chains its carry into the upper word.
                alu_cin   = (op_q[3:2] == 2'b00) ? lo_cout_q : 1'b0;
                alu_sel   = op_q;
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch; the req_* inputs are free to change once accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= 4'd0;
            a_q    <= 64'd0;
            b_q    <= 64'd0;
            cin_q  <= 1'b0;
            wide_q <= 1'b0;
        end else if (req_acc) begin
            op_q   <= req_op;
            a_q    <= req_a;
            b_q    <= req_b;
            cin_q  <= req_cin;
            wide_q <= req_wide;
        end
    end

    // Lower-pass capture, consumed by the carry chain and the shift stitching.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_f_q    <= 32'd0;
            lo_cout_q <= 1'b0;
        end else if (state == LO) begin
            lo_f_q    <= alu_f;
            lo_cout_q <= alu_cout;
        end
    end

    // Merge of both passes: shifts move the bit crossing the word boundary by hand.
    always_comb begin
        wide_f    = {alu_f, lo_f_q};
        wide_cout = alu_cout;
        case (op_q[3:2])
            2'b01: begin
                wide_cout = 1'b0;
            end
            2'b10: begin
                wide_f[31] = lo_f_q[31] | a_q[32];
                wide_cout  = lo_cout_q;
            end
            2'b11: begin
                wide_f[32] = alu_f[0] | lo_cout_q;
                wide_cout  = alu_cout;
            end
            default: begin
                wide_cout = alu_cout;
            end
        endcase
    end

    // Response register, loaded at the end of the final pass and held through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_f    <= 64'd0;
            rsp_cout <= 1'b0;
        end else if (state == LO && !wide_q) begin
            rsp_f    <= {32'd0, alu_f};
            rsp_cout <= alu_cout;
        end else if (state == HI) begin
            rsp_f    <= wide_f;
            rsp_cout <= wide_cout;
        end
    end

`ifdef ALU_SEQ_STATS_EN
    // Completed-response counter, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (rsp_valid && rsp_ready && (op_count != {CNT_W{1'b1}})) begin
            op_count <= op_count + CNT_W'(1);
        end
    end
`endif

endmodule
